nibble_bank_arb: RTL and testbench

Round-robin write arbiter sharing a bank of four 4-bit clock-enabled registers between two requesters (A and B). Each requester presents an address and a nibble. The arbiter grants one writer at a time, drives the per-register clock enables, and exposes a combinational read port plus a saturating write counter. It sits between two producer blocks and the shared register storage.

---
 rtl/nibble_bank_pkg.sv | 13 +
 rtl/dff4_ce.sv | 20 ++
 rtl/nibble_bank_arb.sv | 101 ++++++++++
 tb/tb_nibble_bank_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_bank_pkg.sv
// Shared types and defaults for the nibble bank write arbiter.
package nibble_bank_pkg;

    typedef enum logic {StIdle, StWrite} state_t;

    localparam logic ReqA = 1'b0;
    localparam logic ReqB = 1'b1;

    localparam int unsigned DwDefault   = 4;
    localparam int unsigned NregDefault = 4;
    localparam int unsigned CwDefault   = 8;

endpackage

// File: rtl/dff4_ce.sv
// Clock-enabled register with synchronous clear; clear wins over enable.
module dff4_ce #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/nibble_bank_arb.sv
// Round-robin arbiter granting two requesters write access to a shared register bank,
// with a combinational read port and a saturating write counter.
module nibble_bank_arb
    import nibble_bank_pkg::*;
#(
    parameter int unsigned DW   = DwDefault,
    parameter int unsigned NREG = NregDefault,
    parameter int unsigned AW   = 2,
    parameter int unsigned CW   = CwDefault
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            req_a,
    input  logic [AW-1:0]   addr_a,
    input  logic [DW-1:0]   wdata_a,
    input  logic            req_b,
    input  logic [AW-1:0]   addr_b,
    input  logic [DW-1:0]   wdata_b,
    output logic            gnt_a,
    output logic            gnt_b,
    output logic [NREG-1:0] ce,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata,
    output logic [CW-1:0]   wr_cnt
);

    state_t          state;
    logic            prio;
    logic            id_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;

    logic            win_b;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] sel_ce;
    logic [DW-1:0]   bank [NREG];

    // B wins when it is the only requester or holds priority under contention.
    always_comb begin
        win_b    = req_b && (!req_a || (prio == ReqB));
        sel_addr = win_b ? addr_b : addr_a;
        sel_data = win_b ? wdata_b : wdata_a;
        sel_ce   = NREG'(1) << sel_addr;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= StIdle;
            prio   <= ReqA;
            id_q   <= ReqA;
            addr_q <= '0;
            data_q <= '0;
            gnt_a  <= 1'b0;
            gnt_b  <= 1'b0;
            ce     <= '0;
            wr_cnt <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_a || req_b) begin
                        id_q   <= win_b;
                        addr_q <= sel_addr;
                        data_q <= sel_data;
                        gnt_a  <= !win_b;
                        gnt_b  <= win_b;
                        ce     <= sel_ce;
                        state  <= StWrite;
                    end
                end
                StWrite: begin
                    gnt_a <= 1'b0;
                    gnt_b <= 1'b0;
                    ce    <= '0;
                    prio  <= ~id_q;
                    if (wr_cnt != {CW{1'b1}}) begin
                        wr_cnt <= wr_cnt + CW'(1);
                    end
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // The bank captures data_q on the edge that ends WRITE, while ce is still high.
    for (genvar i = 0; i < NREG; i++) begin : g_bank
        dff4_ce #(
            .W(DW)
        ) u_reg (
            .clk(clk),
            .clr(clr),
            .ce (ce[i]),
            .d  (data_q),
            .q  (bank[i])
        );
    end

    assign rdata = bank[raddr];

endmodule

// File: tb/tb_nibble_bank_arb.sv
// Self-checking bench: vector table plus hand sequences, grants checked against a scoreboard.
module tb_nibble_bank_arb;

    logic       clk = 1'b0;
    logic       clr;
    logic       req_a, req_b;
    logic [1:0] addr_a, addr_b, raddr;
    logic [3:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, gnt_a_s, gnt_b_s;
    logic [3:0] ce, ce_s, rdata, rdata_s;
    logic [7:0] wr_cnt;
    logic [1:0] wr_cnt_s;

    nibble_bank_arb dut (
        .clk(clk), .clr(clr),
        .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .ce(ce),
        .raddr(raddr), .rdata(rdata), .wr_cnt(wr_cnt)
    );

    nibble_bank_arb #(.CW(2)) dut_sat (
        .clk(clk), .clr(clr),
        .req_a(req_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_a(gnt_a_s), .gnt_b(gnt_b_s), .ce(ce_s),
        .raddr(raddr), .rdata(rdata_s), .wr_cnt(wr_cnt_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic [1:0] addr;
        logic [3:0] data;
    } sb_t;

    typedef struct {
        logic       ra;
        logic [1:0] aa;
        logic [3:0] da;
        logic       rb;
        logic [1:0] ab;
        logic [3:0] db;
        logic       exp_b;
    } vec_t;

    sb_t        sb_q[$];
    vec_t       vecs[6];
    logic [3:0] model [4];
    int         n_chk  = 0;
    int         n_pass = 0;
    int         n_wr   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push(input logic b, input logic [1:0] a, input logic [3:0] d);
        sb_t e;
        e.b = b; e.addr = a; e.data = d;
        sb_q.push_back(e);
    endtask

    // Called in a cycle where a grant is visible; pops and compares the expected writer.
    task automatic check_grant();
        sb_t e;
        if (sb_q.size() == 0) begin
            chk("unexpected_grant", {gnt_b, gnt_a}, 0);
            return;
        end
        e = sb_q.pop_front();
        chk("gnt_a", gnt_a, !e.b);
        chk("gnt_b", gnt_b, e.b);
        chk("ce_onehot", ce, 4'b0001 << e.addr);
        model[e.addr] = e.data;
        n_wr++;
    endtask

    task automatic wait_grant(output int lat);
        lat = 0;
        while (!(gnt_a || gnt_b) && lat < 8) begin
            tick();
            lat++;
        end
        chk("grant_seen", gnt_a | gnt_b, 1);
        if (gnt_a || gnt_b) check_grant();
    endtask

    task automatic check_read(input logic [1:0] a);
        raddr = a;
        #1;
        chk($sformatf("rdata@%0d", a), rdata, model[a]);
    endtask

    task automatic check_counts();
        chk("wr_cnt", wr_cnt, n_wr);
        chk("wr_cnt_sat", wr_cnt_s, (n_wr > 3) ? 3 : n_wr);
    endtask

    initial begin
        int lat;
        int grants;
        vecs[0] = '{1'b1, 2'd2, 4'b1010, 1'b0, 2'd0, 4'b0000, 1'b0};
        vecs[1] = '{1'b0, 2'd1, 4'b1110, 1'b1, 2'd0, 4'b0011, 1'b1};
        vecs[2] = '{1'b1, 2'd3, 4'b0110, 1'b1, 2'd3, 4'b1001, 1'b0};
        vecs[3] = '{1'b1, 2'd1, 4'b0111, 1'b1, 2'd2, 4'b1100, 1'b1};
        vecs[4] = '{1'b1, 2'd0, 4'b1111, 1'b0, 2'd1, 4'b0010, 1'b0};
        vecs[5] = '{1'b1, 2'd2, 4'b0001, 1'b1, 2'd0, 4'b0100, 1'b1};
        for (int i = 0; i < 4; i++) model[i] = 4'h0;

        // Reset with random inputs applied
        clr = 1'b1;
        raddr = 2'd0;
        for (int c = 0; c < 2; c++) begin
            req_a = 1'($urandom); req_b = 1'($urandom);
            addr_a = 2'($urandom); addr_b = 2'($urandom);
            wdata_a = 4'($urandom); wdata_b = 4'($urandom);
            tick();
        end
        for (int a = 0; a < 4; a++) check_read(2'(a));
        chk("reset_gnt", {gnt_b, gnt_a}, 0);
        chk("reset_ce", ce, 0);
        check_counts();
        clr = 1'b0; req_a = 1'b0; req_b = 1'b0;
        tick();
        chk("idle_gnt", {gnt_b, gnt_a}, 0);

        // Table-driven single and dual requests
        for (int i = 0; i < 6; i++) begin
            req_a = vecs[i].ra; addr_a = vecs[i].aa; wdata_a = vecs[i].da;
            req_b = vecs[i].rb; addr_b = vecs[i].ab; wdata_b = vecs[i].db;
            push(vecs[i].exp_b, vecs[i].exp_b ? vecs[i].ab : vecs[i].aa,
                 vecs[i].exp_b ? vecs[i].db : vecs[i].da);
            tick();
            wait_grant(lat);
            chk("gnt_latency", lat, 0);
            req_a = 1'b0; req_b = 1'b0;
            tick();
            chk("idle_ce", ce, 0);
            chk("idle_gnt", {gnt_b, gnt_a}, 0);
            check_read(vecs[i].exp_b ? vecs[i].ab : vecs[i].aa);
            check_counts();
        end
        for (int a = 0; a < 4; a++) check_read(2'(a));

        // Contention on one address: A first, then B two cycles later
        req_a = 1'b1; addr_a = 2'd1; wdata_a = 4'b0101;
        req_b = 1'b1; addr_b = 2'd1; wdata_b = 4'b1111;
        push(1'b0, 2'd1, 4'b0101);
        push(1'b1, 2'd1, 4'b1111);
        tick();
        wait_grant(lat);
        req_a = 1'b0;
        tick();
        check_read(2'd1);
        wait_grant(lat);
        chk("second_gnt_gap", lat, 1);
        req_b = 1'b0;
        tick();
        check_read(2'd1);
        chk("contention_final", rdata, 4'b1111);
        check_counts();

        // Fairness under continuous dual request
        req_a = 1'b1; addr_a = 2'd0; wdata_a = 4'b0001;
        req_b = 1'b1; addr_b = 2'd3; wdata_b = 4'b0010;
        for (int k = 0; k < 6; k++) push(k[0], k[0] ? 2'd3 : 2'd0, k[0] ? 4'b0010 : 4'b0001);
        grants = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("gnt_exclusive", gnt_a & gnt_b, 0);
            if (gnt_a || gnt_b) begin
                check_grant();
                grants++;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("fair_grants", grants, 6);
        chk("sb_drained", sb_q.size(), 0);
        tick();
        check_read(2'd0);
        check_read(2'd3);
        check_counts();

        // Clear during WRITE suppresses the write and resets everything
        req_a = 1'b1; addr_a = 2'd3; wdata_a = 4'b0001;
        tick();
        chk("midwrite_gnt_a", gnt_a, 1);
        clr = 1'b1; req_a = 1'b0;
        tick();
        clr = 1'b0;
        for (int a = 0; a < 4; a++) model[a] = 4'h0;
        n_wr = 0;
        check_read(2'd3);
        check_counts();
        chk("clr_gnt", {gnt_b, gnt_a}, 0);
        chk("clr_ce", ce, 0);
        // Idle with prio A: a dual request must be granted to A immediately
        req_a = 1'b1; addr_a = 2'd2; wdata_a = 4'b0011;
        req_b = 1'b1; addr_b = 2'd1; wdata_b = 4'b1000;
        push(1'b0, 2'd2, 4'b0011);
        tick();
        wait_grant(lat);
        chk("post_clr_latency", lat, 0);
        req_a = 1'b0; req_b = 1'b0;
        tick();
        check_read(2'd2);
        check_read(2'd1);
        check_counts();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
